// File: rtl/track_select_ctrl_if.sv
// Playback-control bus between the button/song-player front end and track_select_ctrl.
// The master side drives buttons and song_done; the slave side returns track state.
interface track_select_ctrl_if;
    logic       btn_play;
    logic       btn_next;
    logic       btn_prev;
    logic       song_done;
    logic [3:0] current_track;
    logic       playing;
    logic       track_start;

    modport master (
        output btn_play,
        output btn_next,
        output btn_prev,
        output song_done,
        input  current_track,
        input  playing,
        input  track_start
    );

    modport slave (
        input  btn_play,
        input  btn_next,
        input  btn_prev,
        input  song_done,
        output current_track,
        output playing,
        output track_start
    );
endinterface

// File: rtl/track_select_ctrl.sv
// Playback controller: debounces play/next/prev buttons, runs an IDLE/PLAY FSM and
// keeps a wrapping track index, pulsing track_start whenever playback (re)starts a track.
module track_select_ctrl #(
    parameter int unsigned NUM_TRACKS      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter bit          AUTO_ADVANCE    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    track_select_ctrl_if.slave  bus
);

    localparam int unsigned NUM_BTN  = 3;
    localparam int unsigned BTN_PLAY = 0;
    localparam int unsigned BTN_NEXT = 1;
    localparam int unsigned BTN_PREV = 2;
    localparam int unsigned TRK_W    = 4;
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TRK_W-1:0] TRK_LAST  = TRK_W'(NUM_TRACKS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;
    logic [NUM_BTN-1:0] stable_q;
    logic [NUM_BTN-1:0] stable_d;
    logic [NUM_BTN-1:0] stable_prev_q;
    logic [NUM_BTN-1:0] press_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];

    assign btn_raw = {bus.btn_prev, bus.btn_next, bus.btn_play};

    // A level is accepted only after it has differed from the stable level for
    // DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < NUM_BTN; b++) begin
            cnt_d[b] = '0;
            if (s2_q[b] != stable_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    stable_d[b] = s2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            for (int b = 0; b < NUM_BTN; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            s1_q          <= btn_raw;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            for (int b = 0; b < NUM_BTN; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Playback FSM and track index
    // ------------------------------------------------------------------
    state_e             state_q;
    state_e             state_d;
    logic [TRK_W-1:0]   track_q;
    logic [TRK_W-1:0]   track_d;
    logic               playing_q;
    logic               playing_d;
    logic               start_q;
    logic               start_d;
    logic [TRK_W-1:0]   next_idx;
    logic [TRK_W-1:0]   prev_idx;
    logic               play_press;
    logic               next_press;
    logic               prev_press;

    assign play_press = press_q[BTN_PLAY];
    assign next_press = press_q[BTN_NEXT];
    assign prev_press = press_q[BTN_PREV];

    assign next_idx = (track_q == TRK_LAST) ? '0 : track_q + TRK_W'(1);
    assign prev_idx = (track_q == '0) ? TRK_LAST : track_q - TRK_W'(1);

    // Only the highest-priority event in a cycle is acted on: play > next > prev > song_done.
    always_comb begin
        state_d = state_q;
        track_d = track_q;
        start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (play_press) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end else if (next_press) begin
                    track_d = next_idx;
                end else if (prev_press) begin
                    track_d = prev_idx;
                end
            end
            ST_PLAY: begin
                if (play_press) begin
                    state_d = ST_IDLE;
                end else if (next_press) begin
                    track_d = next_idx;
                    start_d = 1'b1;
                end else if (prev_press) begin
                    track_d = prev_idx;
                    start_d = 1'b1;
                end else if (bus.song_done) begin
                    if (AUTO_ADVANCE) begin
                        track_d = next_idx;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        playing_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            track_q   <= '0;
            playing_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            track_q   <= track_d;
            playing_q <= playing_d;
            start_q   <= start_d;
        end
    end

    assign bus.current_track = track_q;
    assign bus.playing       = playing_q;
    assign bus.track_start   = start_q;

endmodule

// File: tb/tb_track_select_ctrl.sv
// Bench for track_select_ctrl: two instances (auto-advance on/off) share stimulus and are
// compared every cycle against an event-level model, plus vector tables and corner sequences.
module tb_track_select_ctrl;

    localparam int unsigned NT   = 8;
    localparam int unsigned DB   = 4;
    localparam int unsigned GAP  = 10;
    localparam int unsigned NV   = 13;

    localparam int unsigned OP_PLAY = 0;
    localparam int unsigned OP_NEXT = 1;
    localparam int unsigned OP_PREV = 2;
    localparam int unsigned OP_DONE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic       sd;

    always #5 clk = ~clk;

    track_select_ctrl_if ifa ();
    track_select_ctrl_if ifb ();

    assign ifa.btn_play  = btn[0];
    assign ifa.btn_next  = btn[1];
    assign ifa.btn_prev  = btn[2];
    assign ifa.song_done = sd;
    assign ifb.btn_play  = btn[0];
    assign ifb.btn_next  = btn[1];
    assign ifb.btn_prev  = btn[2];
    assign ifb.song_done = sd;

    track_select_ctrl #(.NUM_TRACKS(NT), .DEBOUNCE_CYCLES(DB), .AUTO_ADVANCE(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    track_select_ctrl #(.NUM_TRACKS(NT), .DEBOUNCE_CYCLES(DB), .AUTO_ADVANCE(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned sc [2];

    // Model: raw-sample window per button, accepted level, and the press pipeline.
    bit          win   [3][DB+1];
    bit          stab  [3];
    int unsigned sf    [3];
    bit          pend1 [3];
    bit          pend2 [3];
    int unsigned etrk  [2];
    bit          eplay [2];
    bit          estart[2];

    typedef struct {
        int unsigned op;
        int unsigned hold;
        int unsigned trk_a;
        bit          play_a;
        int unsigned st_a;
        int unsigned trk_b;
        bit          play_b;
        int unsigned st_b;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input int unsigned op, input int unsigned hold,
                                input int unsigned ta, input bit pa, input int unsigned sa,
                                input int unsigned tb, input bit pb, input int unsigned sb);
        vec_t v;
        v.op = op; v.hold = hold;
        v.trk_a = ta; v.play_a = pa; v.st_a = sa;
        v.trk_b = tb; v.play_b = pb; v.st_b = sb;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            stab[b]  = 1'b0;
            sf[b]    = DB;
            pend1[b] = 1'b0;
            pend2[b] = 1'b0;
            for (int i = 0; i <= DB; i++) win[b][i] = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            etrk[j]   = 0;
            eplay[j]  = 1'b0;
            estart[j] = 1'b0;
        end
    endtask

    // One clock edge of the model: a button level is accepted once the last DB
    // synchronized samples (raw delayed by two edges) all disagree with it.
    task automatic model_edge();
        bit ev [3];
        bit diff;
        if (rst) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 3; b++) begin
            ev[b]    = pend2[b];
            pend2[b] = pend1[b];
            pend1[b] = 1'b0;
            if (sf[b] < DB) sf[b]++;
            diff = 1'b1;
            for (int i = 1; i <= DB; i++) if (win[b][i] == stab[b]) diff = 1'b0;
            if (diff && sf[b] >= DB) begin
                stab[b]  = ~stab[b];
                sf[b]    = 0;
                pend1[b] = stab[b];
            end
            for (int i = DB; i > 0; i--) win[b][i] = win[b][i-1];
            win[b][0] = btn[b];
        end
        for (int j = 0; j < 2; j++) begin
            estart[j] = 1'b0;
            if (ev[0]) begin
                estart[j] = ~eplay[j];
                eplay[j]  = ~eplay[j];
            end else if (ev[1]) begin
                etrk[j]   = (etrk[j] + 1) % NT;
                estart[j] = eplay[j];
            end else if (ev[2]) begin
                etrk[j]   = (etrk[j] + NT - 1) % NT;
                estart[j] = eplay[j];
            end else if (sd && eplay[j]) begin
                if (j == 0) begin
                    etrk[j]   = (etrk[j] + 1) % NT;
                    estart[j] = 1'b1;
                end else begin
                    eplay[j] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cmp("cyc trk_a",   32'(ifa.current_track), 32'(etrk[0]));
        cmp("cyc play_a",  32'(ifa.playing),       32'(eplay[0]));
        cmp("cyc start_a", 32'(ifa.track_start),   32'(estart[0]));
        cmp("cyc trk_b",   32'(ifb.current_track), 32'(etrk[1]));
        cmp("cyc play_b",  32'(ifb.playing),       32'(eplay[1]));
        cmp("cyc start_b", 32'(ifb.track_start),   32'(estart[1]));
        if (ifa.track_start === 1'b1) sc[0]++;
        if (ifb.track_start === 1'b1) sc[1]++;
    endtask

    task automatic drive_op(input int unsigned op, input int unsigned hold);
        if (op == OP_DONE) sd = 1'b1;
        else btn[op[1:0]] = 1'b1;
        repeat (hold) step();
        sd  = 1'b0;
        btn = '0;
        repeat (GAP) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        sd  = 1'b0;
        sc[0] = 0;
        sc[1] = 0;
        model_reset();

        step();
        step();
        rst = 1'b0;
        cmp("reset trk_a",  32'(ifa.current_track), 32'd0);
        cmp("reset play_a", 32'(ifa.playing),       32'd0);
        cmp("reset start_a",32'(ifa.track_start),   32'd0);
        repeat (20) step();

        // Press latency: first high sample is edge 1, track moves on edge 8.
        btn[1] = 1'b1;
        repeat (7) step();
        cmp("lat before trk_a", 32'(ifa.current_track), 32'd0);
        step();
        cmp("lat after trk_a", 32'(ifa.current_track), 32'd1);
        cmp("lat after trk_b", 32'(ifb.current_track), 32'd1);
        repeat (2) step();
        btn = '0;
        repeat (GAP) step();

        vecs[0]  = mk(OP_NEXT, 3,  1, 0, 0, 1, 0, 0);
        vecs[1]  = mk(OP_NEXT, 10, 2, 0, 0, 2, 0, 0);
        vecs[2]  = mk(OP_NEXT, 10, 3, 0, 0, 3, 0, 0);
        vecs[3]  = mk(OP_NEXT, 10, 4, 0, 0, 4, 0, 0);
        vecs[4]  = mk(OP_NEXT, 10, 5, 0, 0, 5, 0, 0);
        vecs[5]  = mk(OP_NEXT, 10, 6, 0, 0, 6, 0, 0);
        vecs[6]  = mk(OP_NEXT, 10, 7, 0, 0, 7, 0, 0);
        vecs[7]  = mk(OP_NEXT, 10, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(OP_PREV, 10, 7, 0, 0, 7, 0, 0);
        vecs[9]  = mk(OP_PREV, 10, 6, 0, 0, 6, 0, 0);
        vecs[10] = mk(OP_PREV, 10, 5, 0, 0, 5, 0, 0);
        vecs[11] = mk(OP_PLAY, 10, 5, 1, 1, 5, 1, 1);
        vecs[12] = mk(OP_DONE, 1,  6, 1, 1, 5, 0, 0);

        for (int i = 0; i < NV; i++) begin
            sc[0] = 0;
            sc[1] = 0;
            drive_op(vecs[i].op, vecs[i].hold);
            cmp($sformatf("vec%0d trk_a", i),   32'(ifa.current_track), 32'(vecs[i].trk_a));
            cmp($sformatf("vec%0d play_a", i),  32'(ifa.playing),       32'(vecs[i].play_a));
            cmp($sformatf("vec%0d starts_a", i), 32'(sc[0]),            32'(vecs[i].st_a));
            cmp($sformatf("vec%0d trk_b", i),   32'(ifb.current_track), 32'(vecs[i].trk_b));
            cmp($sformatf("vec%0d play_b", i),  32'(ifb.playing),       32'(vecs[i].play_b));
            cmp($sformatf("vec%0d starts_b", i), 32'(sc[1]),            32'(vecs[i].st_b));
        end

        // song_done in the same cycle as next_press while playing track 3.
        do_reset();
        repeat (3) drive_op(OP_NEXT, 10);
        drive_op(OP_PLAY, 10);
        sc[0] = 0;
        sc[1] = 0;
        btn[1] = 1'b1;
        repeat (7) step();
        sd = 1'b1;
        step();
        sd = 1'b0;
        repeat (2) step();
        btn = '0;
        repeat (GAP) step();
        cmp("coll trk_a",    32'(ifa.current_track), 32'd4);
        cmp("coll play_a",   32'(ifa.playing),       32'd1);
        cmp("coll starts_a", 32'(sc[0]),             32'd1);
        cmp("coll trk_b",    32'(ifb.current_track), 32'd4);
        cmp("coll play_b",   32'(ifb.playing),       32'd1);
        cmp("coll starts_b", 32'(sc[1]),             32'd1);

        // Reset while playing track 6 with prev mid-debounce, then re-debounce the held button.
        drive_op(OP_NEXT, 10);
        drive_op(OP_NEXT, 10);
        cmp("pre-rst trk_a", 32'(ifa.current_track), 32'd6);
        btn[2] = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst trk_a",   32'(ifa.current_track), 32'd0);
        cmp("rst play_a",  32'(ifa.playing),       32'd0);
        cmp("rst start_a", 32'(ifa.track_start),   32'd0);
        cmp("rst trk_b",   32'(ifb.current_track), 32'd0);
        sc[0] = 0;
        sc[1] = 0;
        repeat (10) step();
        btn = '0;
        repeat (GAP) step();
        cmp("post-rst trk_a",    32'(ifa.current_track), 32'd7);
        cmp("post-rst play_a",   32'(ifa.playing),       32'd0);
        cmp("post-rst starts_a", 32'(sc[0]),             32'd0);
        cmp("post-rst trk_b",    32'(ifb.current_track), 32'd7);

        // Random buttons (including short glitches), song_done pulses and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            end
            sd  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        sd  = 1'b0;
        btn = '0;
        repeat (GAP) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
